// File: rtl/qtcore_ctrl_pkg.sv
// Shared types and defaults for the qtcore run controller and its helpers.
package qtcore_ctrl_pkg;

  localparam int CHAIN_LEN_DEFAULT = 160;
  localparam int BIT_CNT_W         = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_UNLOAD,
    ST_FIN
  } ctrl_state_e;

endpackage

// File: rtl/qtcore_bit_counter.sv
// Generic clear/increment counter; at_last flags the value one short of LIMIT,
// so (inc && at_last) is the step that brings the count to LIMIT.
module qtcore_bit_counter #(
  parameter int WIDTH = 12,
  parameter int LIMIT = 160
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_last
);

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_last = (count == LAST_CNT);

endmodule

// File: rtl/qtcore_run_controller.sv
// Load/run/readback sequencer for a qtcore scan chain.
// Readback (UNLOAD state) is built only when QTCORE_READBACK_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | shifting load stream into the scan chain
// RUN    | qtcore executing, watchdog counting
// UNLOAD | shifting the chain out to the readback sink
// FIN    | one-cycle done pulse
module qtcore_run_controller
  import qtcore_ctrl_pkg::*;
#(
  parameter int          CHAIN_LEN  = CHAIN_LEN_DEFAULT,
  parameter logic [15:0] MAX_CYCLES = 16'd65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        load_valid,
  input  logic        load_bit,
  output logic        load_ready,
  input  logic        unload_ready,
  output logic        unload_valid,
  output logic        unload_bit,
  input  logic        halt_in,
  input  logic        scan_out_in,
  output logic        scan_enable,
  output logic        scan_in,
  output logic        proc_en,
  output logic        busy,
  output logic        done,
  output logic        halted,
  output logic        timeout,
  output logic [15:0] cycle_count
);

  ctrl_state_e state, state_nxt;

  logic cnt_clr, cnt_inc, cnt_at_last;
  logic clr_status, set_halt, set_tmo, cyc_inc;

  qtcore_bit_counter #(
    .WIDTH (BIT_CNT_W),
    .LIMIT (CHAIN_LEN)
  ) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .at_last (cnt_at_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    load_ready   = 1'b0;
    unload_valid = 1'b0;
    unload_bit   = 1'b0;
    scan_enable  = 1'b0;
    scan_in      = 1'b0;
    proc_en      = 1'b0;
    done         = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    clr_status   = 1'b0;
    set_halt     = 1'b0;
    set_tmo      = 1'b0;
    cyc_inc      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt  = ST_LOAD;
          cnt_clr    = 1'b1;
          clr_status = 1'b1;
        end
      end

      ST_LOAD: begin
        load_ready  = 1'b1;
        scan_enable = load_valid;
        scan_in     = load_valid & load_bit;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (load_valid) begin
          cnt_inc = 1'b1;
          if (cnt_at_last) state_nxt = ST_RUN;
        end
      end

      ST_RUN: begin
        proc_en = 1'b1;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (halt_in || (cycle_count == MAX_CYCLES)) begin
          // halt takes priority over the watchdog on the same cycle
          set_halt = halt_in;
          set_tmo  = !halt_in;
`ifdef QTCORE_READBACK_EN
          state_nxt = ST_UNLOAD;
          cnt_clr   = 1'b1;
`else
          state_nxt = ST_FIN;
`endif
        end else begin
          cyc_inc = 1'b1;
        end
      end

`ifdef QTCORE_READBACK_EN
      ST_UNLOAD: begin
        unload_valid = 1'b1;
        unload_bit   = scan_out_in;
        scan_enable  = unload_ready;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (unload_ready) begin
          cnt_inc = 1'b1;
          if (cnt_at_last) state_nxt = ST_FIN;
        end
      end
`endif

      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

`ifndef QTCORE_READBACK_EN
  logic unused_rb;
  assign unused_rb = unload_ready ^ scan_out_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= 16'd0;
    end else if (clr_status) begin
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= 16'd0;
    end else begin
      if (set_halt) halted <= 1'b1;
      if (set_tmo) timeout <= 1'b1;
      if (cyc_inc && (cycle_count != 16'hFFFF)) cycle_count <= cycle_count + 16'd1;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_qtcore_run_controller.sv
// Directed bench for qtcore_run_controller (CHAIN_LEN=8, MAX_CYCLES=20);
// readback expectations follow QTCORE_READBACK_EN.
`timescale 1ns/1ps
module tb_qtcore_run_controller;

  localparam int          CL = 8;
  localparam logic [15:0] MC = 16'd20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0;
  logic load_valid = 1'b0, load_bit = 1'b0;
  logic unload_ready = 1'b0, halt_in = 1'b0, scan_out_in = 1'b0;
  logic load_ready, unload_valid, unload_bit, scan_enable, scan_in;
  logic proc_en, busy, done, halted, timeout;
  logic [15:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  qtcore_run_controller #(
    .CHAIN_LEN  (CL),
    .MAX_CYCLES (MC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .load_valid   (load_valid),
    .load_bit     (load_bit),
    .load_ready   (load_ready),
    .unload_ready (unload_ready),
    .unload_valid (unload_valid),
    .unload_bit   (unload_bit),
    .halt_in      (halt_in),
    .scan_out_in  (scan_out_in),
    .scan_enable  (scan_enable),
    .scan_in      (scan_in),
    .proc_en      (proc_en),
    .busy         (busy),
    .done         (done),
    .halted       (halted),
    .timeout      (timeout),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_seq(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_load_ready"}, load_ready, 1);
    check({tag, "_clr_halted"}, halted, 0);
    check({tag, "_clr_timeout"}, timeout, 0);
    check({tag, "_clr_cycles"}, cycle_count, 0);
  endtask

  task automatic load_bits(input string tag, input logic [7:0] d, input bit toggle);
    int k;
    int n;
    k = 0;
    n = toggle ? 15 : 8;
    for (int c = 0; c < n; c++) begin
      logic v;
      v = toggle ? ((c % 2) == 0) : 1'b1;
      load_valid = v;
      load_bit   = v ? d[k] : 1'b1;
      @(negedge clk);
      check($sformatf("%s_se%0d", tag, c), scan_enable, v);
      if (v) check($sformatf("%s_si%0d", tag, c), scan_in, d[k]);
      check($sformatf("%s_pe%0d", tag, c), proc_en, 0);
      if (v) k++;
      tick();
    end
    load_valid = 1'b0;
    load_bit   = 1'b0;
    #1;
    check({tag, "_run_pe"}, proc_en, 1);
    check({tag, "_run_se"}, scan_enable, 0);
  endtask

  task automatic run_cycles(input string tag, input int n, input int halt_at, input int abort_at);
    for (int r = 1; r <= n; r++) begin
      halt_in = (r == halt_at);
      abort   = (r == abort_at);
      @(negedge clk);
      check($sformatf("%s_pe%0d", tag, r), proc_en, 1);
      check($sformatf("%s_excl%0d", tag, r), scan_enable, 0);
      tick();
    end
    halt_in = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic finish_seq(input string tag, input logic [7:0] sout);
    int d0;
`ifdef QTCORE_READBACK_EN
    unload_ready = 1'b1;
    for (int i = 0; i < CL; i++) begin
      scan_out_in = sout[i];
      @(negedge clk);
      check($sformatf("%s_uv%0d", tag, i), unload_valid, 1);
      check($sformatf("%s_ub%0d", tag, i), unload_bit, sout[i]);
      check($sformatf("%s_use%0d", tag, i), scan_enable, 1);
      check($sformatf("%s_upe%0d", tag, i), proc_en, 0);
      tick();
    end
    unload_ready = 1'b0;
    scan_out_in  = 1'b0;
`else
    unload_ready = 1'b1;
    scan_out_in  = sout[0] | 1'b1;
`endif
    d0 = done_cnt;
    @(negedge clk);
    check({tag, "_done"}, done, 1);
    check({tag, "_done_busy"}, busy, 1);
`ifndef QTCORE_READBACK_EN
    check({tag, "_uv_tied"}, unload_valid, 0);
    check({tag, "_ub_tied"}, unload_bit, 0);
    check({tag, "_fin_se"}, scan_enable, 0);
    unload_ready = 1'b0;
    scan_out_in  = 1'b0;
`endif
    tick();
    check({tag, "_done_drop"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    tick();
    tick();
    check({tag, "_one_pulse"}, done_cnt, d0 + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int d0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_pe", proc_en, 0);
    check("rst_se", scan_enable, 0);
    check("rst_done", done, 0);
    check("rst_lr", load_ready, 0);
    check("rst_halted", halted, 0);
    check("rst_cycles", cycle_count, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // A: held-valid load of A5, halt on the 5th RUN cycle
    begin_seq("a");
    load_bits("a_ld", 8'hA5, 1'b0);
    run_cycles("a_run", 5, 5, 0);
    check("a_cycles", cycle_count, 4);
    check("a_halted", halted, 1);
    check("a_timeout", timeout, 0);
    finish_seq("a_fin", 8'h5A);

    // B: toggling valid, watchdog expiry
    begin_seq("b");
    load_bits("b_ld", 8'h3C, 1'b1);
    run_cycles("b_run", 21, 0, 0);
    check("b_cycles", cycle_count, 20);
    check("b_timeout", timeout, 1);
    check("b_halted", halted, 0);
    finish_seq("b_fin", 8'hC3);

    // C: halt on the same cycle the watchdog limit is reached
    begin_seq("c");
    load_bits("c_ld", 8'hFF, 1'b0);
    run_cycles("c_run", 21, 21, 0);
    check("c_cycles", cycle_count, 20);
    check("c_halted", halted, 1);
    check("c_timeout", timeout, 0);
    finish_seq("c_fin", 8'h96);

    // D: abort in RUN
    begin_seq("d");
    load_bits("d_ld", 8'h81, 1'b0);
    d0 = done_cnt;
    run_cycles("d_run", 3, 0, 3);
    check("d_busy", busy, 0);
    check("d_pe", proc_en, 0);
    check("d_cycles", cycle_count, 2);
    check("d_halted", halted, 0);
    check("d_timeout", timeout, 0);
    repeat (3) tick();
    check("d_no_done", done_cnt, d0);

    // E: reset mid-LOAD drops scan_enable without a clock edge
    begin_seq("e");
    load_valid = 1'b1;
    load_bit   = 1'b1;
    repeat (3) tick();
    #2;
    check("e_se_before", scan_enable, 1);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("e_se_async", scan_enable, 0);
    check("e_busy_async", busy, 0);
    check("e_lr_async", load_ready, 0);
    load_valid = 1'b0;
    load_bit   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    check("e_idle", busy, 0);
    check("e_cycles", cycle_count, 0);
    check("e_no_done", done_cnt, d0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
